// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controllers: state encoding and
// the width helper used to size the tick prescaler.
package timer_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] PAUSE  = 3'd3;
    localparam logic [2:0] EXPIRE = 3'd4;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int ceil_log2(input int value);
        int width;
        int span;
        width = 0;
        span  = value - 1;
        while (span > 0) begin
            width = width + 1;
            span  = span >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-CLK_DIV phase counter; tc is high while the phase sits at CLK_DIV-1.
// Synchronous clear takes priority over enable.
module tick_prescaler
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int PW = ceil_log2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase;

    assign tc = (phase == LAST);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tc ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Countdown timer sequencer: IDLE/LOAD/RUN/PAUSE/EXPIRE with a prescaled tick.
// Define TIMER_SEQ_CTRL_IRQ_LATCH_EN to get a sticky irq flag; otherwise irq is 0.
module timer_seq_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         auto_reload,
    input  logic [W-1:0] preset,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         paused,
    output logic         done,
    output logic         irq,
    input  logic         irq_clr
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [2:0] state;
    logic       pre_tc;
    logic       pre_clr;
    logic       pre_en;
    logic       tick;

    // The phase advances on every RUN edge, including the one that enters
    // PAUSE, so a pause of N cycles delays expiry by exactly N cycles.
    assign pre_en  = (state == RUN);
    assign pre_clr = stop || (state == LOAD);
    assign tick    = pre_tc && (state == RUN);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .aclr (aclr),
        .clr  (pre_clr),
        .en   (pre_en),
        .tc   (pre_tc)
    );

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state <= IDLE;
            count <= '0;
        end else if (stop) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= (preset == '0) ? EXPIRE : RUN;
                end
                RUN: begin
                    if (start) begin
                        state <= LOAD;
                    end else if (tick && count == ONE) begin
                        count <= '0;
                        state <= EXPIRE;
                    end else begin
                        if (tick && count != '0) count <= count - ONE;
                        if (pause) state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start)       state <= LOAD;
                    else if (!pause) state <= RUN;
                end
                EXPIRE: begin
                    state <= (auto_reload || start) ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == LOAD) || (state == RUN) || (state == PAUSE);
    assign paused = (state == PAUSE);
    assign done   = (state == EXPIRE);

`ifdef TIMER_SEQ_CTRL_IRQ_LATCH_EN
    // Setting on the EXPIRE cycle beats a coincident clear.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            irq <= 1'b0;
        end else if (state == EXPIRE) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl (CLK_DIV=4, W=8) with a done-pulse scoreboard.
module tb_timer_seq_ctrl;

    localparam int CLK_DIV = 4;
    localparam int W       = 8;
`ifdef TIMER_SEQ_CTRL_IRQ_LATCH_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk;
    logic         aclr;
    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] preset;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         done;
    logic         irq;
    logic         irq_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_exp_q[$];
    int done_obs_q[$];

    timer_seq_ctrl #(
        .CLK_DIV (CLK_DIV),
        .W       (W)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .preset      (preset),
        .count       (count),
        .busy        (busy),
        .paused      (paused),
        .done        (done),
        .irq         (irq),
        .irq_clr     (irq_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Edge number after which each done pulse is visible.
    always @(negedge clk) begin
        if (aclr && done) done_obs_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_timer(input int p, output int s);
        preset = W'(p);
        start  = 1'b1;
        s      = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_dones(input string tag);
        chk({tag, "_done_n"}, done_obs_q.size(), done_exp_q.size());
        while (done_exp_q.size() > 0 && done_obs_q.size() > 0)
            chk({tag, "_done_at"}, done_obs_q.pop_front(), done_exp_q.pop_front());
        done_exp_q.delete();
        done_obs_q.delete();
    endtask

    initial begin
        int s;
        aclr = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        auto_reload = 1'b0; preset = '0; irq_clr = 1'b0;

        #2;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paused", paused, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);

        // Basic countdown, preset 3
        start_timer(3, s);
        done_exp_q.push_back(s + 1 + 3 * CLK_DIV);
        chk("t1_busy_load", busy, 1);
        chk("t1_count_load", count, 0);
        wait_until(s + 1);
        chk("t1_count3", count, 3);
        preset = W'(9);
        wait_until(s + 5);
        chk("t1_count2", count, 2);
        wait_until(s + 9);
        chk("t1_count1", count, 1);
        wait_until(s + 13);
        chk("t1_count0", count, 0);
        chk("t1_done", done, 1);
        wait_until(s + 14);
        chk("t1_idle_busy", busy, 0);
        chk("t1_done_low", done, 0);
        chk("t1_irq_set", irq, IRQ_EN ? 1 : 0);
        irq_clr = 1'b1;
        wait_until(s + 15);
        irq_clr = 1'b0;
        chk("t1_irq_clr", irq, 0);
        wait_until(s + 20);
        check_dones("t1");

        // Zero preset with irq_clr held across EXPIRE
        irq_clr = 1'b1;
        start_timer(0, s);
        done_exp_q.push_back(s + 1);
        wait_until(s + 1);
        chk("t2_done", done, 1);
        chk("t2_count", count, 0);
        wait_until(s + 2);
        chk("t2_irq_setwins", irq, IRQ_EN ? 1 : 0);
        chk("t2_idle", busy, 0);
        irq_clr = 1'b0;
        wait_until(s + 6);
        check_dones("t2");

        // Auto-reload, period P*CLK_DIV+2
        auto_reload = 1'b1;
        start_timer(5, s);
        done_exp_q.push_back(s + 21);
        done_exp_q.push_back(s + 43);
        done_exp_q.push_back(s + 65);
        wait_until(s + 50);
        auto_reload = 1'b0;
        wait_until(s + 66);
        chk("t3_idle", busy, 0);
        wait_until(s + 100);
        check_dones("t3");

        // Pause for 7 cycles mid-RUN
        start_timer(5, s);
        done_exp_q.push_back(s + 21 + 7);
        wait_until(s + 6);
        pause = 1'b1;
        wait_until(s + 8);
        chk("t4_paused", paused, 1);
        chk("t4_count_frz_a", count, 4);
        wait_until(s + 13);
        chk("t4_count_frz_b", count, 4);
        pause = 1'b0;
        wait_until(s + 15);
        chk("t4_resumed", paused, 0);
        chk("t4_count_hold", count, 4);
        wait_until(s + 16);
        chk("t4_count3", count, 3);
        wait_until(s + 40);
        check_dones("t4");

        // stop and start together in RUN
        start_timer(5, s);
        wait_until(s + 6);
        stop = 1'b1;
        start = 1'b1;
        wait_until(s + 7);
        stop = 1'b0;
        start = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_count", count, 0);
        chk("t5_done", done, 0);
        wait_until(s + 40);
        check_dones("t5");

        // Asynchronous reset mid-RUN
        start_timer(5, s);
        wait_until(s + 8);
        #2 aclr = 1'b0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_busy", busy, 0);
        chk("t6_paused", paused, 0);
        chk("t6_done", done, 0);
        chk("t6_irq", irq, 0);
        @(negedge clk);
        aclr = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_idle", busy, 0);
        check_dones("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
